// File: rtl/approx_serial_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : approx_serial_sub_if
// Description : Operand/result handshake bundle for approx_serial_sub.
// Revision    : 1.0 - initial release
// ============================================================================
interface approx_serial_sub_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, diff, borrow, busy
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, diff, borrow, busy
    );
endinterface
`default_nettype wire

// File: rtl/approx_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : approx_serial_sub
// Description : Bit-serial LSB-first A-B (A + ~B + 1) with optional xRN
//               approximate carry on the low APPROX_BITS bits.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_serial_sub #(
    parameter int W           = 8,
    parameter int APPROX_BITS = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    approx_serial_sub_if.slave  bus
);
    localparam int               KW            = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0]    c_K_LAST      = KW'(W - 1);
    localparam logic [KW:0]      c_APPROX_LIM  = (KW+1)'(APPROX_BITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_nb;
    logic           r_mode;
    logic           r_c;
    logic [KW-1:0]  r_k;
    logic           r_pa;
    logic           r_pnb;
    logic [W-1:0]   r_diff;
    logic           r_borrow;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic           w_ak;
    logic           w_nk;
    logic           w_p;
    logic           w_f;
    logic           w_approx;
    logic           w_c_next;
    logic           w_bit;

    assign w_ak = r_a[r_k];
    assign w_nk = r_nb[r_k];
    assign w_p  = w_ak ^ w_nk;

    // xRN carry: i4=ak, i3=nk, i2=c, i1=previous ak, i0=previous nk
    assign w_f = (~w_ak & ~w_nk &  r_c &  r_pa)
               | (~w_ak &  w_nk & ~r_c &  r_pa)
               | ( w_nk &  r_c  &  r_pnb)
               | ( w_ak & ~w_nk & ~r_c &  r_pnb)
               | ( w_ak &  r_c  & ~r_pa)
               | ( w_ak &  w_nk & ~r_pa)
               | ( w_ak &  w_nk &  r_c);

    assign w_approx = r_mode && ({1'b0, r_k} < c_APPROX_LIM);
    assign w_c_next = w_approx ? w_f
                               : ((w_ak & w_nk) | (w_ak & r_c) | (w_nk & r_c));
    assign w_bit    = w_p ^ (w_approx ? w_f : r_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_nb        <= '0;
            r_mode      <= 1'b0;
            r_c         <= 1'b0;
            r_k         <= '0;
            r_pa        <= 1'b0;
            r_pnb       <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_nb       <= ~bus.b;
                        r_mode     <= bus.mode;
                        r_c        <= 1'b1;
                        r_k        <= '0;
                        r_pa       <= 1'b0;
                        r_pnb      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff[r_k] <= w_bit;
                    r_c         <= w_c_next;
                    r_pa        <= w_ak;
                    r_pnb       <= w_nk;
                    r_k         <= r_k + KW'(1);
                    if (r_k == c_K_LAST) begin
                        r_borrow    <= ~w_c_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Release returns to IDLE only; acceptance waits a cycle
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_approx_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_serial_sub
// Description : Drives three builds (APPROX_BITS 4, 0, W) in lock-step and
//               compares results against an arithmetic/bit-loop reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_serial_sub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    int checks   = 0;
    int failures = 0;

    approx_serial_sub_if #(.W(W)) if4 ();
    approx_serial_sub_if #(.W(W)) if0 ();
    approx_serial_sub_if #(.W(W)) if8 ();

    assign if4.in_valid = in_valid; assign if4.a = a; assign if4.b = b;
    assign if4.mode = mode;         assign if4.out_ready = out_ready;
    assign if0.in_valid = in_valid; assign if0.a = a; assign if0.b = b;
    assign if0.mode = mode;         assign if0.out_ready = out_ready;
    assign if8.in_valid = in_valid; assign if8.a = a; assign if8.b = b;
    assign if8.mode = mode;         assign if8.out_ready = out_ready;

    approx_serial_sub #(.W(W), .APPROX_BITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    approx_serial_sub #(.W(W), .APPROX_BITS(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    approx_serial_sub #(.W(W), .APPROX_BITS(W)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    always #5 clk = ~clk;

    function automatic logic xrn(input logic i4, i3, i2, i1, i0);
        return (~i4 & ~i3 & i2 & i1) | (~i4 & i3 & ~i2 & i1) | (i3 & i2 & i0)
             | (i4 & ~i3 & ~i2 & i0) | (i4 & i2 & ~i1) | (i4 & i3 & ~i1)
             | (i4 & i3 & i2);
    endfunction

    // Returns {borrow, diff}
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, y,
                                              input logic m, input int ab);
        logic [W-1:0] ny, d;
        logic c, pa, pnb, t;
        logic [1:0] s;
        if (!m || ab == 0)
            return {(x < y), W'(x - y)};
        ny = ~y; c = 1'b1; pa = 1'b0; pnb = 1'b0; d = '0;
        for (int k = 0; k < W; k++) begin
            if (k < ab) begin
                t    = xrn(x[k], ny[k], c, pa, pnb);
                d[k] = x[k] ^ ny[k] ^ t;
                c    = t;
            end else begin
                s    = 2'(x[k]) + 2'(ny[k]) + 2'(c);
                d[k] = s[0];
                c    = s[1];
            end
            pa = x[k]; pnb = ny[k];
        end
        return {~c, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_results(input logic [W:0] e4, e0, e8, input string tag);
        chk({tag, "_diff4"}, 32'(if4.diff), 32'(e4[W-1:0]));
        chk({tag, "_bor4"},  32'(if4.borrow), 32'(e4[W]));
        chk({tag, "_diff0"}, 32'(if0.diff), 32'(e0[W-1:0]));
        chk({tag, "_bor0"},  32'(if0.borrow), 32'(e0[W]));
        chk({tag, "_diff8"}, 32'(if8.diff), 32'(e8[W-1:0]));
        chk({tag, "_bor8"},  32'(if8.borrow), 32'(e8[W]));
    endtask

    task automatic do_op(input logic [W-1:0] x, y, input logic m, input int stall,
                         input string tag);
        logic [W:0] e4, e0, e8;
        int cyc;
        e4 = ref_result(x, y, m, 4);
        e0 = ref_result(x, y, m, 0);
        e8 = ref_result(x, y, m, W);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'({if4.in_ready, if0.in_ready, if8.in_ready}), 32'h7);
        a = x; b = y; mode = m; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = ~x; b = ~y; mode = ~m;
        chk({tag, "_busy"}, 32'({if4.busy, if4.in_ready}), 32'h2);
        cyc = 1;
        while (!if4.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(W + 1));
        chk({tag, "_ov_all"}, 32'({if0.out_valid, if8.out_valid}), 32'h3);
        chk_results(e4, e0, e8, tag);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk({tag, "_hold"}, 32'({if4.out_valid, if4.in_ready, if4.diff}),
                32'({1'b1, 1'b0, e4[W-1:0]}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, 32'({if4.out_valid, if4.in_ready, if4.busy}), 32'h2);
        chk({tag, "_held_diff"}, 32'(if4.diff), 32'(e4[W-1:0]));
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        a = 8'hA7; b = 8'h12; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("rst_midrun_busy", 32'({if4.busy, if4.in_ready}), 32'h2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_state4", 32'({if4.in_ready, if4.out_valid, if4.busy, if4.borrow}), 32'h8);
        chk("rst_diff4", 32'(if4.diff), 32'h0);
        chk("rst_state8", 32'({if8.in_ready, if8.out_valid, if8.diff}), 32'h200);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_flags", 32'({if4.in_ready, if4.out_valid, if4.busy, if4.borrow}), 32'h8);
        chk("reset_diff", 32'(if4.diff), 32'h0);

        do_op(8'd5, 8'd3, 1'b0, 0, "t2");
        do_op(8'd3, 8'd5, 1'b0, 0, "t3");
        do_op(8'h00, 8'h00, 1'b1, 0, "t4");
        chk("t4_known", 32'({if4.borrow, if4.diff}), 32'h1FF);
        reset_mid_run();
        do_op(8'h80, 8'h01, 1'b1, 0, "t5");
        chk("t5_known", 32'({if0.borrow, if0.diff}), 32'h07F);
        do_op(8'h5A, 8'hC3, 1'b1, 5, "t6");

        for (int n = 0; n < 12; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
